// File: rtl/alu_seq_driver_if.sv
// Bundle between a command source / response sink (master) and alu_seq_driver (slave).
// Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
// valid and its payload stay stable until that edge, and ready may depend on state only.
interface alu_seq_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
  logic       cmd_sweep;
  logic [3:0] cmd_sel_last;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       carry_out;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic [3:0] rsp_sel;
  logic       rsp_last;
  logic [15:0] op_count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_sweep, cmd_sel_last,
    output alu_out, carry_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_data, rsp_carry, rsp_sel, rsp_last, op_count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_sweep, cmd_sel_last,
    input  alu_out, carry_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_data, rsp_carry, rsp_sel, rsp_last, op_count
  );
endinterface

// File: rtl/alu_seq_driver.sv
// Drives an external combinational ALU with one operand pair across one select or a
// select sweep, waiting SETTLE_CYCLES (1..15) before capturing each result.
module alu_seq_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_driver_if.slave  bus,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Counter counts down to zero; the capture edge is the one that sees zero.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  settle_q;
  logic        sweep_q;
  logic [3:0]  last_sel_q;
  logic [7:0]  alu_a_q;
  logic [7:0]  alu_b_q;
  logic [3:0]  alu_sel_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_carry_q;
  logic [3:0]  rsp_sel_q;
  logic        rsp_valid_q;
  logic        rsp_last_q;
  logic [15:0] op_count_q;
  logic [15:0] op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'h0001;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settle_q    <= 4'h0;
      sweep_q     <= 1'b0;
      last_sel_q  <= 4'h0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_sel_q   <= 4'h0;
      rsp_data_q  <= 8'h00;
      rsp_carry_q <= 1'b0;
      rsp_sel_q   <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      op_count_q  <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_q    <= bus.cmd_a;
            alu_b_q    <= bus.cmd_b;
            alu_sel_q  <= bus.cmd_sel;
            sweep_q    <= bus.cmd_sweep;
            last_sel_q <= bus.cmd_sel_last;
            settle_q   <= SETTLE_LOAD;
            state_q    <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_q == 4'h0) begin
            rsp_data_q  <= bus.alu_out;
            rsp_carry_q <= bus.carry_out;
            rsp_sel_q   <= alu_sel_q;
            rsp_last_q  <= !sweep_q || (alu_sel_q == last_sel_q);
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            settle_q <= settle_q - 4'h1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            op_count_q  <= op_count_d;
            // Select wraps mod 16, so a sweep always reaches its last select within 16 steps.
            if (!rsp_last_q) begin
              alu_sel_q <= alu_sel_q + 4'h1;
              settle_q  <= SETTLE_LOAD;
              state_q   <= DRIVE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && rst_n;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_sel   = rsp_sel_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.op_count  = op_count_q;
  assign state_o       = state_q;

endmodule
